// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the burst controller of the 1024x8 single-port RAM:
// FSM state encoding, default bus widths and the RAM rw pin polarity.
package mem_ctrl_pkg;

   // Default widths; the controller exposes them as overridable parameters.
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_LEN_W  = 4;

   // RAM rw pin polarity.
   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE      = 2'd1,
      READ       = 2'd2,
      READ_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
// Bus master for a single-port synchronous RAM with a shared tri-state data
// bus. Accepts burst read/write commands over valid/ready, streams write beats
// into the RAM and registered read beats out.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_rw, cmd_addr, cmd_len    command: 1 = write; start address; beats - 1
//   wr_valid/wr_ready, wr_data   write beat stream (ready throughout WRITE)
//   rd_valid, rd_data, rd_last   registered read beats, no backpressure
//   busy                         state != IDLE
//   mem_addr, mem_cs, mem_rw     RAM control pins
//   mem_data                     RAM data bus, driven only on writes
module mem_burst_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_cs,
   output logic              mem_rw,
   inout  wire  [DATA_W-1:0] mem_data
);

   state_t             state_reg, state_next;
   logic [LEN_W-1:0]   cnt_reg, cnt_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   // Set on read accept: the first READ cycle only issues an address, the
   // RAM has nothing on the bus yet.
   logic               first_reg, first_next;
   logic               rd_valid_reg, rd_valid_next;
   logic               rd_last_reg, rd_last_next;
   logic [DATA_W-1:0]  rd_data_reg, rd_data_next;
   logic               capture;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      first_next = first_reg;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               addr_next  = cmd_addr;
               cnt_next   = cmd_len;
               first_next = 1'b1;
               state_next = (cmd_rw == RW_WRITE) ? WRITE : READ;
            end
         end
         WRITE: begin
            if (wr_valid) begin
               addr_next = addr_reg + ADDR_W'(1);
               if (cnt_reg == '0) state_next = IDLE;
               else               cnt_next   = cnt_reg - LEN_W'(1);
            end
         end
         READ: begin
            addr_next  = addr_reg + ADDR_W'(1);
            first_next = 1'b0;
            if (cnt_reg == '0) state_next = READ_DRAIN;
            else               cnt_next   = cnt_reg - LEN_W'(1);
         end
         READ_DRAIN: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The RAM drives the word addressed in the previous cycle, so every READ
   // cycle except the first, plus the drain cycle, carries a valid word.
   always_comb begin
      capture       = ((state_reg == READ) && !first_reg) || (state_reg == READ_DRAIN);
      rd_valid_next = capture;
      rd_last_next  = (state_reg == READ_DRAIN);
      rd_data_next  = capture ? mem_data : rd_data_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         addr_reg     <= '0;
         first_reg    <= 1'b0;
         rd_valid_reg <= 1'b0;
         rd_last_reg  <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         addr_reg     <= addr_next;
         first_reg    <= first_next;
         rd_valid_reg <= rd_valid_next;
         rd_last_reg  <= rd_last_next;
         rd_data_reg  <= rd_data_next;
      end
   end

   always_comb begin
      cmd_ready = (state_reg == IDLE);
      busy      = (state_reg != IDLE);
      wr_ready  = (state_reg == WRITE);
      mem_rw    = (state_reg == WRITE) ? RW_WRITE : RW_READ;
      mem_cs    = 1'b0;
      // addr_reg already advanced past the final read address; the drain
      // cycle re-presents that last address so the RAM keeps the word up.
      mem_addr  = (state_reg == READ_DRAIN) ? addr_reg - ADDR_W'(1) : addr_reg;
      case (state_reg)
         WRITE:      mem_cs = wr_valid;
         READ:       mem_cs = 1'b1;
         READ_DRAIN: mem_cs = 1'b1;
         default:    mem_cs = 1'b0;
      endcase
   end

   assign rd_valid = rd_valid_reg;
   assign rd_last  = rd_last_reg;
   assign rd_data  = rd_data_reg;

   // Only drive the bus during an actual write beat; reads leave it to the RAM.
   assign mem_data = (mem_cs && mem_rw) ? wr_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rw = 1'b0;
   logic [9:0] cmd_addr = '0;
   logic [3:0] cmd_len = '0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = '0;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       rd_last;
   logic       busy;
   logic [9:0] mem_addr;
   logic       mem_cs;
   logic       mem_rw;
   wire  [7:0] mem_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_burst_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy), .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_rw(mem_rw),
      .mem_data(mem_data)
   );

   // Behavioural 1024x8 synchronous RAM with a write log.
   logic [7:0] ram [0:1023];
   logic [9:0] wlog [0:255];
   int         wcnt = 0;
   logic       ram_oe = 1'b0;
   logic [7:0] ram_q = '0;

   always @(posedge clk) begin
      if (mem_cs && mem_rw) begin
         ram[mem_addr]     <= mem_data;
         wlog[wcnt[7:0]]   <= mem_addr;
         wcnt              <= wcnt + 1;
      end
      ram_oe <= mem_cs && !mem_rw;
      ram_q  <= ram[mem_addr];
   end

   assign mem_data = (ram_oe && !mem_rw) ? ram_q : 8'hzz;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'hC3;
      tick(); tick();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %0b expected 0", wr_ready); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
      checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %0b expected 0", rd_last); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h expected 00", rd_data); end
      checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL reset_mem_cs: got %0b expected 0", mem_cs); end
      checks++; if (mem_rw !== 1'b0) begin errors++; $display("FAIL reset_mem_rw: got %0b expected 0", mem_rw); end
      checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr: got %0h expected 000", mem_addr); end
      checks++; if (mem_data === 8'hC3) begin errors++; $display("FAIL reset_mem_data: got %0h expected not driven", mem_data); end
      rst = 1'b0; wr_valid = 1'b0;
      tick();
      $display("reset: done");
   endtask

   task automatic test_write_wrap();
      int w0;
      logic [9:0] ea;
      logic [7:0] ed;
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 10'h3FE; cmd_len = 4'd3; wr_valid = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready: got %0b expected 1", cmd_ready); end
      w0 = wcnt;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ea = 10'(10'h3FE + i);
         ed = 8'(8'hA0 + i);
         wr_valid = 1'b1; wr_data = ed;
         #1;
         checks++; if (mem_cs !== 1'b1) begin errors++; $display("FAIL wr_cs beat %0d: got %0b expected 1", i, mem_cs); end
         checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL wr_rw beat %0d: got %0b expected 1", i, mem_rw); end
         checks++; if (mem_addr !== ea) begin errors++; $display("FAIL wr_addr beat %0d: got %0h expected %0h", i, mem_addr, ea); end
         checks++; if (mem_data !== ed) begin errors++; $display("FAIL wr_bus beat %0d: got %0h expected %0h", i, mem_data, ed); end
         tick();
      end
      wr_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %0b expected 0", busy); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_end: got %0b expected 1", cmd_ready); end
      checks++; if (wcnt - w0 != 4) begin errors++; $display("FAIL wr_count: got %0d expected 4", wcnt - w0); end
      for (int i = 0; i < 4; i++) begin
         ea = 10'(10'h3FE + i);
         ed = 8'(8'hA0 + i);
         checks++; if (ram[ea] !== ed) begin errors++; $display("FAIL wr_ram %0h: got %0h expected %0h", ea, ram[ea], ed); end
      end
      $display("write: 4 beats at 3fe");
   endtask

   task automatic test_read_burst();
      logic [9:0] ea;
      logic [7:0] ed;
      wr_valid = 1'b0; wr_data = 8'hC3;
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 10'h3FE; cmd_len = 4'd3;
      tick();
      cmd_valid = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         #1;
         checks++; if (rd_valid !== (k >= 3 && k <= 6)) begin errors++; $display("FAIL rd_valid T+%0d: got %0b", k, rd_valid); end
         if (k >= 3 && k <= 6) begin
            ed = 8'(8'hA0 + k - 3);
            checks++; if (rd_data !== ed) begin errors++; $display("FAIL rd_data T+%0d: got %0h expected %0h", k, rd_data, ed); end
         end
         checks++; if (rd_last !== (k == 6)) begin errors++; $display("FAIL rd_last T+%0d: got %0b expected %0b", k, rd_last, k == 6); end
         checks++; if (cmd_ready !== (k >= 6)) begin errors++; $display("FAIL rd_cmd_ready T+%0d: got %0b expected %0b", k, cmd_ready, k >= 6); end
         checks++; if (mem_cs !== (k <= 5)) begin errors++; $display("FAIL rd_cs T+%0d: got %0b expected %0b", k, mem_cs, k <= 5); end
         if (k <= 5) begin
            ea = 10'(10'h3FE + ((k <= 4) ? k - 1 : 3));
            checks++; if (mem_addr !== ea) begin errors++; $display("FAIL rd_addr T+%0d: got %0h expected %0h", k, mem_addr, ea); end
         end
         checks++; if (mem_data === 8'hC3) begin errors++; $display("FAIL rd_contention T+%0d: bus %0h while rw=%0b", k, mem_data, mem_rw); end
         tick();
      end
      $display("read: 4 beats at 3fe");
   endtask

   task automatic test_single_read();
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 10'h010; cmd_len = 4'd0;
      tick();
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'h5A;
      tick();
      wr_valid = 1'b0; wr_data = 8'hC3;
      tick();
      checks++; if (ram[10'h010] !== 8'h5A) begin errors++; $display("FAIL single_preload: got %0h expected 5a", ram[10'h010]); end
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 10'h010; cmd_len = 4'd0;
      tick();
      cmd_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         checks++; if (mem_cs !== (k <= 2)) begin errors++; $display("FAIL single_cs T+%0d: got %0b expected %0b", k, mem_cs, k <= 2); end
         checks++; if (rd_valid !== (k == 3)) begin errors++; $display("FAIL single_valid T+%0d: got %0b expected %0b", k, rd_valid, k == 3); end
         checks++; if (rd_last !== (k == 3)) begin errors++; $display("FAIL single_last T+%0d: got %0b expected %0b", k, rd_last, k == 3); end
         if (k == 3) begin
            checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL single_data: got %0h expected 5a", rd_data); end
         end
         tick();
      end
      $display("read: single beat at 010");
   endtask

   task automatic test_write_stall();
      int pat [5] = '{1, 0, 0, 1, 1};
      int w0;
      int b;
      logic [9:0] ea;
      logic [7:0] ed;
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 10'h100; cmd_len = 4'd2;
      w0 = wcnt;
      b = 0;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wr_valid = (pat[k] != 0);
         wr_data = (pat[k] != 0) ? 8'(8'hB0 + b) : 8'h77;
         #1;
         checks++; if (mem_cs !== wr_valid) begin errors++; $display("FAIL stall_cs cycle %0d: got %0b expected %0b", k, mem_cs, wr_valid); end
         checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL stall_wr_ready cycle %0d: got %0b expected 1", k, wr_ready); end
         if (pat[k] != 0) b++;
         tick();
      end
      wr_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end: got %0b expected 0", busy); end
      checks++; if (wcnt - w0 != 3) begin errors++; $display("FAIL stall_count: got %0d expected 3", wcnt - w0); end
      for (int i = 0; i < 3; i++) begin
         ea = 10'(10'h100 + i);
         ed = 8'(8'hB0 + i);
         checks++; if (wlog[8'(w0 + i)] !== ea) begin errors++; $display("FAIL stall_log %0d: got %0h expected %0h", i, wlog[8'(w0 + i)], ea); end
         checks++; if (ram[ea] !== ed) begin errors++; $display("FAIL stall_ram %0h: got %0h expected %0h", ea, ram[ea], ed); end
      end
      $display("write: 3 beats at 100 with stalls");
   endtask

   task automatic test_back_to_back();
      int beats;
      wr_valid = 1'b0; wr_data = 8'hC3;
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 10'h000; cmd_len = 4'd15;
      tick();
      cmd_addr = 10'h3FE; cmd_len = 4'd0;
      beats = 0;
      for (int k = 1; k <= 18; k++) begin
         checks++; if (cmd_ready !== (k == 18)) begin errors++; $display("FAIL b2b_ready T+%0d: got %0b expected %0b", k, cmd_ready, k == 18); end
         checks++; if (mem_data === 8'hC3) begin errors++; $display("FAIL b2b_contention T+%0d: bus %0h while rw=%0b", k, mem_data, mem_rw); end
         if (rd_valid === 1'b1) begin
            beats++;
            if (beats == 1) begin
               checks++; if (rd_data !== 8'hA2) begin errors++; $display("FAIL b2b_beat0: got %0h expected a2", rd_data); end
            end
            if (beats == 2) begin
               checks++; if (rd_data !== 8'hA3) begin errors++; $display("FAIL b2b_beat1: got %0h expected a3", rd_data); end
            end
         end
         checks++; if (rd_last !== (k == 18)) begin errors++; $display("FAIL b2b_last T+%0d: got %0b expected %0b", k, rd_last, k == 18); end
         tick();
      end
      cmd_valid = 1'b0;
      #1;
      checks++; if (beats != 16) begin errors++; $display("FAIL b2b_beats: got %0d expected 16", beats); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy %0b expected 1", busy); end
      checks++; if (mem_addr !== 10'h3FE) begin errors++; $display("FAIL b2b_second_addr: got %0h expected 3fe", mem_addr); end
      tick(); tick();
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %0b expected 1", rd_valid); end
      checks++; if (rd_data !== 8'hA0) begin errors++; $display("FAIL b2b_second_data: got %0h expected a0", rd_data); end
      checks++; if (rd_last !== 1'b1) begin errors++; $display("FAIL b2b_second_last: got %0b expected 1", rd_last); end
      tick();
      $display("read: 16 beats at 000 then 1 beat at 3fe");
   endtask

   task automatic test_reset_mid_write();
      int w0;
      logic [9:0] ea;
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 10'h200; cmd_len = 4'd7;
      w0 = wcnt;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = 8'(8'hD0 + i);
         if (i == 2) rst = 1'b1;
         tick();
      end
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %0b expected 0", busy); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstw_cmd_ready: got %0b expected 1", cmd_ready); end
      checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL rstw_cs: got %0b expected 0", mem_cs); end
      checks++; if (mem_data === wr_data) begin errors++; $display("FAIL rstw_bus: got %0h expected not driven", mem_data); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstw_rd_valid: got %0b expected 0", rd_valid); end
      rst = 1'b0; wr_valid = 1'b0;
      tick(); tick();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstw_rd_valid_after: got %0b expected 0", rd_valid); end
      checks++; if (wcnt - w0 != 3) begin errors++; $display("FAIL rstw_count: got %0d expected 3", wcnt - w0); end
      for (int i = 0; i < 3; i++) begin
         ea = 10'(10'h200 + i);
         checks++; if (wlog[8'(w0 + i)] !== ea) begin errors++; $display("FAIL rstw_log %0d: got %0h expected %0h", i, wlog[8'(w0 + i)], ea); end
      end
      $display("write: 8-beat burst at 200 aborted by reset");
   endtask

   initial begin
      test_reset();
      test_write_wrap();
      test_read_burst();
      test_single_read();
      test_write_stall();
      test_back_to_back();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
